// File: rtl/commit_trace_monitor.sv
// Commit trace monitor: captures retiring instructions into a trace FIFO,
// counts commits and run cycles, and stops on halt instruction or hang timeout.
module commit_trace_monitor #(
    parameter int          COMMIT_WIDTH   = 2,
    parameter int          DEPTH          = 16,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] HALT_INST      = 32'h00100073
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_in_start,
    input  logic [COMMIT_WIDTH-1:0]    io_in_commit,
    input  logic [32*COMMIT_WIDTH-1:0] io_in_pc,
    input  logic [32*COMMIT_WIDTH-1:0] io_in_inst,
    output logic                       io_out_trace_valid,
    input  logic                       io_in_trace_ready,
    output logic [31:0]                io_out_trace_pc,
    output logic [31:0]                io_out_trace_inst,
    output logic [31:0]                io_out_trace_seq,
    output logic [31:0]                io_out_inst_count,
    output logic [31:0]                io_out_cycle_count,
    output logic                       io_out_halted,
    output logic                       io_out_timeout,
    output logic                       io_out_overflow
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED, ST_TIMEOUT} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] seq;
    } entry_t;

    state_t             state_q, state_d;
    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx;
    logic [CNT_W-1:0]   count_q, count_d, cap, n_push;
    logic [31:0]        inst_cnt_q, inst_cnt_d, cyc_cnt_q, cyc_cnt_d, n_commit;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               halted_q, halted_d, timeout_q, timeout_d, ovf_q, ovf_d;
    logic               halt_seen, pop;

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        inst_cnt_d = inst_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        idle_d     = idle_q;
        halted_d   = halted_q;
        timeout_d  = timeout_q;
        ovf_d      = ovf_q;
        n_push     = '0;
        n_commit   = '0;
        halt_seen  = 1'b0;
        wr_idx     = wr_ptr_q;
        // Capacity is fixed by start-of-cycle occupancy; a same-cycle pop frees nothing.
        cap        = CNT_W'(DEPTH) - count_q;

        if (state_q == ST_RUN) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (io_in_commit[i] && !halt_seen) begin
                    if (n_push < cap) begin
                        wr_idx        = wr_ptr_q + n_push[PTR_W-1:0];
                        mem_d[wr_idx] = '{pc:   io_in_pc[32*i +: 32],
                                          inst: io_in_inst[32*i +: 32],
                                          seq:  inst_cnt_q + n_commit};
                        n_push        = n_push + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    n_commit = n_commit + 32'd1;
                    if (io_in_inst[32*i +: 32] == HALT_INST) halt_seen = 1'b1;
                end
            end
            wr_ptr_d   = wr_ptr_q + n_push[PTR_W-1:0];
            inst_cnt_d = inst_cnt_q + n_commit;
            if (n_commit != '0) begin
                idle_d = '0;
                if (halt_seen) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end
            end else begin
                idle_d = idle_q + IDLE_W'(1);
                if (idle_d == IDLE_W'(TIMEOUT_CYCLES)) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end
            end
        end else if (state_q == ST_IDLE && io_in_start) begin
            state_d = ST_RUN;
        end

        pop      = (count_q != '0) && io_in_trace_ready;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + n_push - CNT_W'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inst_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            idle_q     <= '0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inst_cnt_q <= inst_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            idle_q     <= idle_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            ovf_q      <= ovf_d;
        end
    end

    // Head fields read as zero whenever the FIFO is empty.
    assign io_out_trace_valid = (count_q != '0);
    assign io_out_trace_pc    = io_out_trace_valid ? mem_q[rd_ptr_q].pc   : '0;
    assign io_out_trace_inst  = io_out_trace_valid ? mem_q[rd_ptr_q].inst : '0;
    assign io_out_trace_seq   = io_out_trace_valid ? mem_q[rd_ptr_q].seq  : '0;
    assign io_out_inst_count  = inst_cnt_q;
    assign io_out_cycle_count = cyc_cnt_q;
    assign io_out_halted      = halted_q;
    assign io_out_timeout     = timeout_q;
    assign io_out_overflow    = ovf_q;
endmodule

// File: tb/tb_commit_trace_monitor.sv
// Bench for commit_trace_monitor: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_commit_trace_monitor;
    localparam int          CW       = 2;
    localparam int          DEPTH    = 16;
    localparam int          TMO      = 1024;
    localparam logic [31:0] HALT     = 32'h00100073;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] commit = '0;
    logic [63:0]   pc = '0, inst = '0;
    logic          ready = 1'b0;
    logic          valid, halted, timeout, overflow;
    logic [31:0]   t_pc, t_inst, t_seq, icnt, ccnt;

    int n_checks = 0;
    int n_fail   = 0;

    commit_trace_monitor #(.COMMIT_WIDTH(CW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .HALT_INST(HALT)) dut (
        .clock(clock), .reset(reset), .io_in_start(start), .io_in_commit(commit),
        .io_in_pc(pc), .io_in_inst(inst), .io_out_trace_valid(valid),
        .io_in_trace_ready(ready), .io_out_trace_pc(t_pc), .io_out_trace_inst(t_inst),
        .io_out_trace_seq(t_seq), .io_out_inst_count(icnt), .io_out_cycle_count(ccnt),
        .io_out_halted(halted), .io_out_timeout(timeout), .io_out_overflow(overflow)
    );

    always #5 clock = ~clock;

    // Reference model: trace is a queue of {pc, inst, seq}; mode 0 idle, 1 run, 2 halted, 3 timed out.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] seq;
    } ent_t;
    ent_t        m_q[$];
    int          m_mode = 0;
    int          m_idle = 0;
    logic [31:0] m_ic = '0, m_cc = '0;
    logic        m_h = 1'b0, m_t = 1'b0, m_o = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            m_mode = 0; m_idle = 0; m_ic = '0; m_cc = '0;
            m_h = 1'b0; m_t = 1'b0; m_o = 1'b0;
        end else begin
            bit do_pop;
            int room;
            bit stop, any;
            do_pop = (m_q.size() > 0) && ready;
            room   = DEPTH - m_q.size();
            stop   = 0;
            any    = 0;
            if (m_mode == 1) begin
                m_cc = m_cc + 1;
                for (int i = 0; i < CW; i++) begin
                    if (commit[i] && !stop) begin
                        any = 1;
                        if (room > 0) begin
                            m_q.push_back('{pc[32*i +: 32], inst[32*i +: 32], m_ic});
                            room--;
                        end else m_o = 1'b1;
                        m_ic = m_ic + 1;
                        if (inst[32*i +: 32] == HALT) stop = 1;
                    end
                end
                if (stop) begin m_mode = 2; m_h = 1'b1; m_idle = 0; end
                else if (any) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle == TMO) begin m_mode = 3; m_t = 1'b1; end
                end
            end else if (m_mode == 0 && start) m_mode = 1;
            if (do_pop) void'(m_q.pop_front());
        end
    end

    task automatic tick; @(negedge clock); endtask

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; commit = '0; ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if ({valid, t_pc, t_inst, t_seq} !== 97'd0) begin
            n_fail++; $display("FAIL reset_trace: got %h required 0", {valid, t_pc, t_inst, t_seq});
        end
        n_checks++;
        if ({icnt, ccnt, halted, timeout, overflow} !== 67'd0) begin
            n_fail++; $display("FAIL reset_status: got %h required 0", {icnt, ccnt, halted, timeout, overflow});
        end
    endtask

    task automatic test_order;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        commit = 2'b11; pc = {32'h80000004, 32'h80000000}; inst = {NOP, NOP};
        tick(); commit = '0;
        n_checks++;
        if ({valid, t_pc, t_seq, icnt} !== {1'b1, 32'h80000000, 32'd0, 32'd2}) begin
            n_fail++; $display("FAIL order_first: got v=%b pc=%h seq=%0d cnt=%0d required 1 80000000 0 2", valid, t_pc, t_seq, icnt);
        end
        ready = 1'b1; tick();
        n_checks++;
        if ({valid, t_pc, t_seq} !== {1'b1, 32'h80000004, 32'd1}) begin
            n_fail++; $display("FAIL order_second: got v=%b pc=%h seq=%0d required 1 80000004 1", valid, t_pc, t_seq);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL order_empty: got valid=%b required 0", valid); end
        ready = 1'b0;
    endtask

    task automatic test_compaction;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        commit = 2'b10; pc = {32'h00000100, 32'hdeadbeef}; inst = {NOP, NOP};
        tick(); commit = '0;
        n_checks++;
        if ({valid, t_pc, t_seq, icnt} !== {1'b1, 32'h100, 32'd0, 32'd1}) begin
            n_fail++; $display("FAIL compact_head: got v=%b pc=%h seq=%0d cnt=%0d required 1 100 0 1", valid, t_pc, t_seq, icnt);
        end
        ready = 1'b1; tick(); ready = 1'b0;
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL compact_single: got valid=%b required 0", valid); end
    endtask

    task automatic test_overflow;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        inst = {NOP, NOP};
        for (int c = 0; c < 9; c++) begin
            commit = 2'b11; pc = {32'h1000 + 32'(8*c + 4), 32'h1000 + 32'(8*c)};
            tick();
            if (c == 7) begin
                n_checks++;
                if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full_exact: got %b required 0", overflow); end
            end
        end
        commit = '0;
        n_checks++;
        if ({overflow, icnt, ccnt} !== {1'b1, 32'd18, 32'd9}) begin
            n_fail++; $display("FAIL ovf_status: got ovf=%b cnt=%0d cyc=%0d required 1 18 9", overflow, icnt, ccnt);
        end
        ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            n_checks++;
            if ({valid, t_seq, t_pc} !== {1'b1, 32'(k), 32'h1000 + 32'(4*k)}) begin
                n_fail++; $display("FAIL ovf_drain[%0d]: got v=%b seq=%0d pc=%h required seq=%0d", k, valid, t_seq, t_pc, k);
            end
            tick();
        end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL ovf_held16: got valid=%b required 0", valid); end
        ready = 1'b0;
    endtask

    task automatic test_halt;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        commit = 2'b11; pc = {32'h204, 32'h200}; inst = {NOP, HALT};
        tick();
        n_checks++;
        if ({halted, icnt, valid, t_inst, t_seq} !== {1'b1, 32'd1, 1'b1, HALT, 32'd0}) begin
            n_fail++; $display("FAIL halt_state: got h=%b cnt=%0d v=%b inst=%h seq=%0d required 1 1 1 %h 0", halted, icnt, valid, t_inst, t_seq, HALT);
        end
        inst = {NOP, NOP}; start = 1'b1;
        tick(); tick();
        start = 1'b0; commit = '0;
        n_checks++;
        if ({icnt, ccnt, halted} !== {32'd1, 32'd1, 1'b1}) begin
            n_fail++; $display("FAIL halt_ignore: got cnt=%0d cyc=%0d h=%b required 1 1 1", icnt, ccnt, halted);
        end
        ready = 1'b1; tick(); ready = 1'b0;
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL halt_one_entry: got valid=%b required 0", valid); end
    endtask

    task automatic test_timeout;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        repeat (TMO - 1) tick();
        n_checks++;
        if ({timeout, ccnt} !== {1'b0, 32'(TMO - 1)}) begin
            n_fail++; $display("FAIL tmo_early: got t=%b cyc=%0d required 0 %0d", timeout, ccnt, TMO - 1);
        end
        tick();
        n_checks++;
        if ({timeout, ccnt, halted} !== {1'b1, 32'(TMO), 1'b0}) begin
            n_fail++; $display("FAIL tmo_hit: got t=%b cyc=%0d h=%b required 1 %0d 0", timeout, ccnt, halted, TMO);
        end
        tick();
        n_checks++;
        if (ccnt !== 32'(TMO)) begin n_fail++; $display("FAIL tmo_frozen: got cyc=%0d required %0d", ccnt, TMO); end
        reset = 1'b1; start = 1'b1; commit = 2'b11; inst = {NOP, NOP};
        tick();
        reset = 1'b0; start = 1'b0;
        n_checks++;
        if ({valid, t_pc, t_inst, t_seq, icnt, ccnt, halted, timeout, overflow} !== 164'd0) begin
            n_fail++; $display("FAIL tmo_reset: got %h required 0", {valid, t_pc, t_inst, t_seq, icnt, ccnt, halted, timeout, overflow});
        end
        tick(); commit = '0;
        n_checks++;
        if ({icnt, valid} !== 33'd0) begin
            n_fail++; $display("FAIL reset_to_idle: got cnt=%0d v=%b required 0 0", icnt, valid);
        end
    endtask

    task automatic test_random;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            reset  = ($urandom_range(0, 199) == 0);
            start  = ($urandom_range(0, 3) == 0);
            commit = CW'($urandom);
            ready  = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < CW; i++) begin
                pc[32*i +: 32]   = $urandom;
                inst[32*i +: 32] = ($urandom_range(0, 39) == 0) ? HALT : $urandom;
            end
            tick();
            n_checks++;
            if (valid !== (m_q.size() > 0)) begin
                n_fail++; $display("FAIL rand_valid[%0d]: got %b required %b", c, valid, m_q.size() > 0);
            end else if (m_q.size() > 0 && {t_pc, t_inst, t_seq} !== {m_q[0].pc, m_q[0].inst, m_q[0].seq}) begin
                n_fail++; $display("FAIL rand_head[%0d]: got %h %h %0d required %h %h %0d", c, t_pc, t_inst, t_seq, m_q[0].pc, m_q[0].inst, m_q[0].seq);
            end
            n_checks++;
            if ({icnt, ccnt, halted, timeout, overflow} !== {m_ic, m_cc, m_h, m_t, m_o}) begin
                n_fail++; $display("FAIL rand_status[%0d]: got cnt=%0d cyc=%0d h%b t%b o%b required cnt=%0d cyc=%0d h%b t%b o%b",
                                   c, icnt, ccnt, halted, timeout, overflow, m_ic, m_cc, m_h, m_t, m_o);
            end
        end
        reset = 1'b0; start = 1'b0; commit = '0; ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_order();
        test_compaction();
        test_overflow();
        test_halt();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
